// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default timing constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   localparam int unsigned MD_LAT_DEF      = 32'd8;
   localparam int unsigned MEM_TIMEOUT_DEF = 32'd64;
   localparam int unsigned CNT_W_DEF       = 32'd16;

endpackage

// File: rtl/pipeline_stall_ctrl_muldiv_busy_counter.sv
// Tracks how long the mult/div unit still owns HI/LO after an issue.
module muldiv_busy_counter #(
   parameter int unsigned MD_LAT = 32'd8,
   parameter int unsigned MD_W   = $clog2(MD_LAT + 32'd1)
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic md_busy
);

   localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT);
   localparam logic [MD_W-1:0] MD_ONE  = MD_W'(1);
   localparam logic [MD_W-1:0] MD_ZERO = MD_W'(0);

   logic [MD_W-1:0] md_cnt_q;
   logic [MD_W-1:0] md_cnt_d;

   // Load wins over the decrement; the unit keeps counting even while the pipe is frozen.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (load) begin
         md_cnt_d = MD_LOAD;
      end else if (md_cnt_q != MD_ZERO) begin
         md_cnt_d = md_cnt_q - MD_ONE;
      end else begin
         md_cnt_d = md_cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         md_cnt_q <= MD_ZERO;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

   assign md_busy = (md_cnt_q != MD_ZERO);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: memory-wait freeze, branch flush, HI/LO and load-use stalls.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MD_LAT      = MD_LAT_DEF,
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ldUseStall,
   input  logic             IDIsMulDiv,
   input  logic             IDUsesHiLo,
   input  logic             memReq,
   input  logic             memReady,
   input  logic             branchTaken,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             HazMuxCon,
   output logic             IDEXWrite,
   output logic             EXMEMWrite,
   output logic             MEMWBWrite,
   output logic             IFIDFlush,
   output logic             IDEXFlush,
   output logic             mdBusy,
   output logic             memErr,
   output logic [CNT_W-1:0] stallCount
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 32'd1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                mem_err_q, mem_err_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic                freeze;
   logic                hilo_stall;
   logic                md_load;

   assign freeze     = memReq & ~memReady;
   assign hilo_stall = (IDUsesHiLo | IDIsMulDiv) & mdBusy;
   assign md_load    = IDIsMulDiv & ~mdBusy & ~freeze & ~branchTaken & ~ldUseStall;

   muldiv_busy_counter #(.MD_LAT(MD_LAT)) u_md_cnt (
      .clk     (clk),
      .rst     (rst),
      .load    (md_load),
      .md_busy (mdBusy)
   );

   // Priority: freeze holds everything, a branch kills IF/ID and ID, then ID stalls.
   always_comb begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      HazMuxCon  = 1'b1;
      IDEXWrite  = 1'b1;
      EXMEMWrite = 1'b1;
      MEMWBWrite = 1'b1;
      IFIDFlush  = 1'b0;
      IDEXFlush  = 1'b0;
      if (rst) begin
         PCWrite = 1'b1;
      end else if (freeze) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEXWrite  = 1'b0;
         EXMEMWrite = 1'b0;
         MEMWBWrite = 1'b0;
      end else if (branchTaken) begin
         IFIDFlush = 1'b1;
         IDEXFlush = 1'b1;
      end else if (hilo_stall | ldUseStall) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         HazMuxCon = 1'b0;
      end else begin
         PCWrite = 1'b1;
      end
   end

   // Memory-wait FSM; the wait counter saturates at the timeout.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            if (freeze) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_ONE;
            end else begin
               wait_cnt_d = WAIT_ZERO;
            end
         end
         MEM_WAIT: begin
            if (!freeze) begin
               state_d    = RUN;
               wait_cnt_d = WAIT_ZERO;
            end else if (wait_cnt_q != WAIT_MAX) begin
               wait_cnt_d = wait_cnt_q + WAIT_ONE;
            end else begin
               wait_cnt_d = wait_cnt_q;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = WAIT_ZERO;
         end
      endcase
   end

   // Sticky timeout flag and saturating stall counter.
   always_comb begin
      mem_err_d   = mem_err_q | (wait_cnt_d == WAIT_MAX);
      stall_cnt_d = stall_cnt_q;
      if (!PCWrite && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= WAIT_ZERO;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= CNT_ZERO;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign memErr     = mem_err_q;
   assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-count reference model.
module tb_pipeline_stall_ctrl;

   localparam int MD_LAT      = 8;
   localparam int MEM_TIMEOUT = 64;
   localparam int CNT_W       = 6;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, ldUseStall, IDIsMulDiv, IDUsesHiLo, memReq, memReady, branchTaken;
   logic PCWrite, IFIDWrite, HazMuxCon, IDEXWrite, EXMEMWrite, MEMWBWrite;
   logic IFIDFlush, IDEXFlush, mdBusy, memErr;
   logic [CNT_W-1:0] stallCount;

   int checks = 0;
   int failures = 0;

   // reference model: remaining mult/div cycles, consecutive freeze cycles, sticky error, stalls
   int md_remain = 0;
   int wait_run  = 0;
   int stalls    = 0;
   bit err       = 1'b0;

   pipeline_stall_ctrl #(.MD_LAT(MD_LAT), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ldUseStall(ldUseStall), .IDIsMulDiv(IDIsMulDiv),
      .IDUsesHiLo(IDUsesHiLo), .memReq(memReq), .memReady(memReady), .branchTaken(branchTaken),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .HazMuxCon(HazMuxCon), .IDEXWrite(IDEXWrite),
      .EXMEMWrite(EXMEMWrite), .MEMWBWrite(MEMWBWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
      .mdBusy(mdBusy), .memErr(memErr), .stallCount(stallCount)
   );

   wire [9:0] act = {PCWrite, IFIDWrite, HazMuxCon, IDEXWrite, EXMEMWrite, MEMWBWrite,
                     IFIDFlush, IDEXFlush, mdBusy, memErr};

   // expected {PC,IFID,HazMux,IDEX,EXMEM,MEMWB,IFIDFlush,IDEXFlush,mdBusy,memErr}
   function automatic logic [9:0] exp_ctl();
      logic [7:0] w;
      bit frz;
      bit busy;
      frz  = memReq & ~memReady;
      busy = (md_remain > 0);
      if (rst)                                          w = 8'b11111100;
      else if (frz)                                     w = 8'b00100000;
      else if (branchTaken)                             w = 8'b11111111;
      else if (ldUseStall || ((IDUsesHiLo || IDIsMulDiv) && busy)) w = 8'b00011100;
      else                                              w = 8'b11111100;
      return {w, busy, err};
   endfunction

   task automatic apply(input logic [6:0] v);
      {rst, ldUseStall, IDIsMulDiv, IDUsesHiLo, memReq, memReady, branchTaken} = v;
   endtask

   task automatic tick();
      logic [9:0] e;
      bit frz;
      bit busy;
      e    = exp_ctl();
      frz  = memReq & ~memReady;
      busy = (md_remain > 0);
      if (rst) begin
         md_remain = 0; wait_run = 0; stalls = 0; err = 1'b0;
      end else begin
         if (!e[9] && stalls < CNT_MAX) stalls++;
         if (IDIsMulDiv && !busy && !frz && !branchTaken && !ldUseStall) md_remain = MD_LAT;
         else if (busy) md_remain--;
         if (frz) begin
            if (wait_run < MEM_TIMEOUT) wait_run++;
            if (wait_run >= MEM_TIMEOUT) err = 1'b1;
         end else begin
            wait_run = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      apply(7'b1000000);
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         apply(7'b1000101);
         @(negedge clk);
         checks++;
         if ({act, stallCount} !== {exp_ctl(), CNT_W'(stalls)}) begin
            failures++;
            $display("FAIL reset cyc%0d: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", i, act, stallCount, exp_ctl(), stalls);
         end
         tick();
      end
      apply(7'b0000000);
      @(negedge clk);
      checks++;
      if ({mdBusy, memErr, stallCount, PCWrite, HazMuxCon} !== {1'b0, 1'b0, 6'd0, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL reset_vals: got busy=%b err=%b cnt=%0d pc=%b haz=%b", mdBusy, memErr, stallCount, PCWrite, HazMuxCon);
      end
      tick();
   endtask

   task automatic test_ld_use();
      do_reset();
      apply(7'b0100000);
      @(negedge clk);
      checks++;
      if ({PCWrite, IFIDWrite, HazMuxCon, IDEXWrite, EXMEMWrite, MEMWBWrite} !== 6'b000111) begin
         failures++;
         $display("FAIL ld_use_ctl: got %b want 000111", {PCWrite, IFIDWrite, HazMuxCon, IDEXWrite, EXMEMWrite, MEMWBWrite});
      end
      tick();
      apply(7'b0000000);
      @(negedge clk);
      checks++;
      if ({act, stallCount} !== {exp_ctl(), CNT_W'(stalls)} || stallCount !== 6'd1) begin
         failures++;
         $display("FAIL ld_use_cnt: got ctl=%b cnt=%0d want ctl=%b cnt=1", act, stallCount, exp_ctl());
      end
      tick();
   endtask

   task automatic test_muldiv_hilo();
      int n_stall;
      n_stall = 0;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         apply(i == 0 ? 7'b0010000 : 7'b0001000);
         @(negedge clk);
         checks++;
         if ({act, stallCount} !== {exp_ctl(), CNT_W'(stalls)}) begin
            failures++;
            $display("FAIL muldiv cyc%0d: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", i, act, stallCount, exp_ctl(), stalls);
         end
         if (!PCWrite) n_stall++;
         tick();
      end
      checks++;
      if (n_stall != MD_LAT || mdBusy !== 1'b0 || PCWrite !== 1'b1) begin
         failures++;
         $display("FAIL muldiv_len: got stalls=%0d busy=%b pc=%b want 8/0/1", n_stall, mdBusy, PCWrite);
      end
   endtask

   task automatic test_mem_wait();
      logic [6:0] seq [5];
      seq = '{7'b0000100, 7'b0000100, 7'b0000100, 7'b0000110, 7'b0000000};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply(seq[i]);
         @(negedge clk);
         checks++;
         if ({act, stallCount} !== {exp_ctl(), CNT_W'(stalls)}) begin
            failures++;
            $display("FAIL mem_wait cyc%0d: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", i, act, stallCount, exp_ctl(), stalls);
         end
         tick();
      end
      checks++;
      if (stallCount !== 6'd3 || memErr !== 1'b0) begin
         failures++;
         $display("FAIL mem_wait_end: got cnt=%0d err=%b want 3/0", stallCount, memErr);
      end
   endtask

   task automatic test_timeout();
      int first_err;
      first_err = -1;
      do_reset();
      for (int i = 0; i < 74; i++) begin
         apply(i < 70 ? 7'b0000100 : 7'b0000000);
         @(negedge clk);
         checks++;
         if ({act, stallCount} !== {exp_ctl(), CNT_W'(stalls)}) begin
            failures++;
            $display("FAIL timeout cyc%0d: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", i, act, stallCount, exp_ctl(), stalls);
         end
         if (memErr === 1'b1 && first_err < 0) first_err = i;
         tick();
      end
      checks++;
      if (first_err != MEM_TIMEOUT || memErr !== 1'b1 || stallCount !== 6'd63) begin
         failures++;
         $display("FAIL timeout_edge: got first=%0d err=%b cnt=%0d want 64/1/63", first_err, memErr, stallCount);
      end
      do_reset();
      apply(7'b0000000);
      @(negedge clk);
      checks++;
      if (memErr !== 1'b0) begin
         failures++;
         $display("FAIL timeout_clear: got err=%b want 0", memErr);
      end
      tick();
   endtask

   task automatic test_branch();
      logic [6:0] seq [4];
      seq = '{7'b0100001, 7'b0100101, 7'b0100101, 7'b0100111};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(seq[i]);
         @(negedge clk);
         checks++;
         if ({act, stallCount} !== {exp_ctl(), CNT_W'(stalls)}) begin
            failures++;
            $display("FAIL branch cyc%0d: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", i, act, stallCount, exp_ctl(), stalls);
         end
         checks++;
         if ({IFIDFlush, IDEXFlush, PCWrite, HazMuxCon} !== ((i == 1 || i == 2) ? 4'b0001 : 4'b1111)) begin
            failures++;
            $display("FAIL branch_flush cyc%0d: got %b", i, {IFIDFlush, IDEXFlush, PCWrite, HazMuxCon});
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] seq [6];
      seq = '{7'b0010000, 7'b0000100, 7'b0000100, 7'b0000100, 7'b1000100, 7'b0000000};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         apply(seq[i]);
         @(negedge clk);
         checks++;
         if ({act, stallCount} !== {exp_ctl(), CNT_W'(stalls)}) begin
            failures++;
            $display("FAIL reset_mid cyc%0d: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", i, act, stallCount, exp_ctl(), stalls);
         end
         if (i == 5) begin
            checks++;
            if ({mdBusy, stallCount, act[9:2]} !== {1'b0, 6'd0, 8'b11111100}) begin
               failures++;
               $display("FAIL reset_mid_vals: got busy=%b cnt=%0d ctl=%b", mdBusy, stallCount, act[9:2]);
            end
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [6:0] v;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         v[6] = ($urandom_range(0, 63) == 0);
         v[5] = ($urandom_range(0, 4) == 0);
         v[4] = ($urandom_range(0, 2) == 0);
         v[3] = ($urandom_range(0, 2) == 0);
         v[2] = ($urandom_range(0, 1) == 0);
         v[1] = ($urandom_range(0, 1) == 0);
         v[0] = ($urandom_range(0, 6) == 0);
         apply(v);
         @(negedge clk);
         checks++;
         if ({act, stallCount} !== {exp_ctl(), CNT_W'(stalls)}) begin
            failures++;
            $display("FAIL random cyc%0d in=%b: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", i, v, act, stallCount, exp_ctl(), stalls);
         end
         tick();
      end
   endtask

   initial begin
      apply(7'b1000000);
      @(posedge clk);
      #1;
      test_reset();
      test_ld_use();
      test_muldiv_hilo();
      test_mem_wait();
      test_timeout();
      test_branch();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
